// File: rtl/gpr_scoreboard_file.sv
// Register file with a busy-bit scoreboard: two async read ports, one write-back port, one reservation port.
// Optional macro GPR_BYPASS_EN forwards write-back data/busy into reads and the reservation check.
module gpr_scoreboard_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_dest,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_dest,
    output logic                rsv_ok,
    input  logic [ADDR_W-1:0]   rd_addr_1,
    output logic [DATA_W-1:0]   rd_data_1,
    output logic                rd_busy_1,
    input  logic [ADDR_W-1:0]   rd_addr_2,
    output logic [DATA_W-1:0]   rd_data_2,
    output logic                rd_busy_2,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [ADDR_W:0]     busy_cnt
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     cnt_d;
    logic                rsvTargetBusy;

    // A busy target refuses the reservation (WAW guard); the requester retries.
    always_comb begin
        rsvTargetBusy = busy_q[rsv_dest];
`ifdef GPR_BYPASS_EN
        if (wr_en && (wr_dest == rsv_dest)) begin
            rsvTargetBusy = 1'b0;
        end
`endif
        rsv_ok = rsv_en & ~rsvTargetBusy;
    end

    // Reservation is applied after write-back, so a same-index collision leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_dest] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_dest] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_comb begin
        rd_data_1 = regs_q[rd_addr_1];
        rd_busy_1 = busy_q[rd_addr_1];
        rd_data_2 = regs_q[rd_addr_2];
        rd_busy_2 = busy_q[rd_addr_2];
`ifdef GPR_BYPASS_EN
        if (wr_en && (wr_dest == rd_addr_1)) begin
            rd_data_1 = wr_data;
            rd_busy_1 = 1'b0;
        end
        if (wr_en && (wr_dest == rd_addr_2)) begin
            rd_data_2 = wr_data;
            rd_busy_2 = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                regs_q[wr_dest] <= wr_data;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_gpr_scoreboard_file.sv
// Scoreboard bench for gpr_scoreboard_file: expectations are queued when stimulus is driven
// and popped when the DUT output is sampled; honours GPR_BYPASS_EN when defined.
module tb_gpr_scoreboard_file;

`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_dest = '0;
    logic [15:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [2:0]  rsv_dest = '0;
    logic        rsv_ok;
    logic [2:0]  rd_addr_1 = '0;
    logic [15:0] rd_data_1;
    logic        rd_busy_1;
    logic [2:0]  rd_addr_2 = '0;
    logic [15:0] rd_data_2;
    logic        rd_busy_2;
    logic [7:0]  busy_vec;
    logic [3:0]  busy_cnt;

    logic [31:0] sbq [$];
    logic [31:0] want;
    logic [7:0]  mBusy = '0;
    int          vectors = 0;
    int          miscompares = 0;

    gpr_scoreboard_file #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_dest(rsv_dest), .rsv_ok(rsv_ok),
        .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1), .rd_busy_1(rd_busy_1),
        .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2), .rd_busy_2(rd_busy_2),
        .busy_vec(busy_vec), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        #1 reset_n = 1'b0;
        sbq.push_back(32'h0);
        sbq.push_back(32'h0);
        sbq.push_back(32'h0);
        #2;
        want = sbq.pop_front(); vectors++;
        if (32'(busy_vec) !== want) begin miscompares++; $display("[TB] FAIL reset busy_vec got %0h expected %0h", busy_vec, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(busy_cnt) !== want) begin miscompares++; $display("[TB] FAIL reset busy_cnt got %0d expected %0d", busy_cnt, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(rd_data_1) !== want) begin miscompares++; $display("[TB] FAIL reset rd_data_1 got %0h expected %0h", rd_data_1, want); end
        cyc();
        reset_n = 1'b1;
        mBusy = '0;
    endtask

    task automatic test_reserve_write();
        rsv_en = 1'b1; rsv_dest = 3'd3; rd_addr_1 = 3'd3;
        sbq.push_back(32'd1);
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(rsv_ok) !== want) begin miscompares++; $display("[TB] FAIL rsv_r3 rsv_ok got %0b expected %0b", rsv_ok, want); end
        cyc();
        idle();
        mBusy[3] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sbq.push_back(32'd1);
            sbq.push_back(32'($countones(mBusy)));
            @(negedge clk);
            want = sbq.pop_front(); vectors++;
            if (32'(rd_busy_1) !== want) begin miscompares++; $display("[TB] FAIL pending_r3 rd_busy_1 cycle %0d got %0b expected %0b", k, rd_busy_1, want); end
            want = sbq.pop_front(); vectors++;
            if (32'(busy_cnt) !== want) begin miscompares++; $display("[TB] FAIL pending_r3 busy_cnt got %0d expected %0d", busy_cnt, want); end
            cyc();
        end
        wr_en = 1'b1; wr_dest = 3'd3; wr_data = 16'hBEEF;
        sbq.push_back(BYP ? 32'd0 : 32'd1);
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(rd_busy_1) !== want) begin miscompares++; $display("[TB] FAIL wb_cycle rd_busy_1 got %0b expected %0b", rd_busy_1, want); end
        cyc();
        idle();
        mBusy[3] = 1'b0;
        sbq.push_back(32'hBEEF);
        sbq.push_back(32'd0);
        sbq.push_back(32'd0);
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(rd_data_1) !== want) begin miscompares++; $display("[TB] FAIL after_wb rd_data_1 got %0h expected %0h", rd_data_1, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(rd_busy_1) !== want) begin miscompares++; $display("[TB] FAIL after_wb rd_busy_1 got %0b expected %0b", rd_busy_1, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(busy_cnt) !== want) begin miscompares++; $display("[TB] FAIL after_wb busy_cnt got %0d expected %0d", busy_cnt, want); end
    endtask

    task automatic test_refuse();
        cyc();
        rsv_en = 1'b1; rsv_dest = 3'd5;
        cyc();
        mBusy[5] = 1'b1;
        sbq.push_back(32'd0);
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(rsv_ok) !== want) begin miscompares++; $display("[TB] FAIL refuse_r5 rsv_ok got %0b expected %0b", rsv_ok, want); end
        cyc();
        idle();
        sbq.push_back(32'h20);
        sbq.push_back(32'd1);
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(busy_vec) !== want) begin miscompares++; $display("[TB] FAIL refuse_r5 busy_vec got %0h expected %0h", busy_vec, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(busy_cnt) !== want) begin miscompares++; $display("[TB] FAIL refuse_r5 busy_cnt got %0d expected %0d", busy_cnt, want); end
    endtask

    task automatic test_same_cycle();
        cyc();
        rsv_en = 1'b1; rsv_dest = 3'd2;
        cyc();
        mBusy[2] = 1'b1;
        wr_en = 1'b1; wr_dest = 3'd2; wr_data = 16'h1234;
        rd_addr_2 = 3'd2;
        sbq.push_back(32'(BYP));
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(rsv_ok) !== want) begin miscompares++; $display("[TB] FAIL collide_r2 rsv_ok got %0b expected %0b", rsv_ok, want); end
        cyc();
        idle();
        mBusy[2] = BYP;
        sbq.push_back(32'h1234);
        sbq.push_back(32'(BYP));
        sbq.push_back(32'(mBusy));
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(rd_data_2) !== want) begin miscompares++; $display("[TB] FAIL collide_r2 rd_data_2 got %0h expected %0h", rd_data_2, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(rd_busy_2) !== want) begin miscompares++; $display("[TB] FAIL collide_r2 rd_busy_2 got %0b expected %0b", rd_busy_2, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(busy_vec) !== want) begin miscompares++; $display("[TB] FAIL collide_r2 busy_vec got %0h expected %0h", busy_vec, want); end
        cyc();
        wr_en = 1'b1; wr_dest = 3'd5; wr_data = 16'h5555;
        rsv_en = 1'b1; rsv_dest = 3'd6;
        sbq.push_back(32'd1);
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(rsv_ok) !== want) begin miscompares++; $display("[TB] FAIL split_w5_r6 rsv_ok got %0b expected %0b", rsv_ok, want); end
        cyc();
        idle();
        mBusy[5] = 1'b0;
        mBusy[6] = 1'b1;
        sbq.push_back(32'(mBusy));
        sbq.push_back(32'($countones(mBusy)));
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(busy_vec) !== want) begin miscompares++; $display("[TB] FAIL split_w5_r6 busy_vec got %0h expected %0h", busy_vec, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(busy_cnt) !== want) begin miscompares++; $display("[TB] FAIL split_w5_r6 busy_cnt got %0d expected %0d", busy_cnt, want); end
    endtask

    task automatic test_bypass_read();
        cyc();
        rd_addr_1 = 3'd7; rd_addr_2 = 3'd3;
        wr_en = 1'b1; wr_dest = 3'd7; wr_data = 16'hA5A5;
        sbq.push_back(BYP ? 32'hA5A5 : 32'h0);
        sbq.push_back(32'hBEEF);
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(rd_data_1) !== want) begin miscompares++; $display("[TB] FAIL wr_r7 same-cycle rd_data_1 got %0h expected %0h", rd_data_1, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(rd_data_2) !== want) begin miscompares++; $display("[TB] FAIL wr_r7 rd_data_2 got %0h expected %0h", rd_data_2, want); end
        cyc();
        idle();
        rd_addr_2 = 3'd7;
        sbq.push_back(32'hA5A5);
        sbq.push_back(32'hA5A5);
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(rd_data_1) !== want) begin miscompares++; $display("[TB] FAIL wr_r7 next-cycle rd_data_1 got %0h expected %0h", rd_data_1, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(rd_data_2) !== want) begin miscompares++; $display("[TB] FAIL wr_r7 next-cycle rd_data_2 got %0h expected %0h", rd_data_2, want); end
    endtask

    task automatic test_midrun_reset();
        for (int i = 0; i < 8; i++) begin
            if (mBusy[i]) begin
                cyc();
                wr_en = 1'b1; wr_dest = 3'(i); wr_data = 16'h0F0F;
            end
        end
        cyc();
        idle();
        mBusy = '0;
        rsv_en = 1'b1; rsv_dest = 3'd0;
        cyc();
        rsv_dest = 3'd2;
        cyc();
        idle();
        rd_addr_1 = 3'd3; rd_addr_2 = 3'd7;
        sbq.push_back(32'h05);
        sbq.push_back(32'd2);
        #1;
        want = sbq.pop_front(); vectors++;
        if (32'(busy_vec) !== want) begin miscompares++; $display("[TB] FAIL prereset busy_vec got %0h expected %0h", busy_vec, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(busy_cnt) !== want) begin miscompares++; $display("[TB] FAIL prereset busy_cnt got %0d expected %0d", busy_cnt, want); end
        reset_n = 1'b0;
        sbq.push_back(32'h0);
        sbq.push_back(32'h0);
        sbq.push_back(32'h0);
        sbq.push_back(32'h0);
        #1;
        want = sbq.pop_front(); vectors++;
        if (32'(busy_vec) !== want) begin miscompares++; $display("[TB] FAIL midreset busy_vec got %0h expected %0h", busy_vec, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(busy_cnt) !== want) begin miscompares++; $display("[TB] FAIL midreset busy_cnt got %0d expected %0d", busy_cnt, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(rd_data_1) !== want) begin miscompares++; $display("[TB] FAIL midreset rd_data_1 got %0h expected %0h", rd_data_1, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(rd_data_2) !== want) begin miscompares++; $display("[TB] FAIL midreset rd_data_2 got %0h expected %0h", rd_data_2, want); end
        cyc();
        reset_n = 1'b1;
        mBusy = '0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            rsv_en = 1'b1; rsv_dest = 3'(i);
            sbq.push_back(32'd1);
            @(negedge clk);
            want = sbq.pop_front(); vectors++;
            if (32'(rsv_ok) !== want) begin miscompares++; $display("[TB] FAIL fill r%0d rsv_ok got %0b expected %0b", i, rsv_ok, want); end
            cyc();
            mBusy[i] = 1'b1;
        end
        rsv_dest = 3'd4;
        sbq.push_back(32'hFF);
        sbq.push_back(32'd8);
        sbq.push_back(32'd0);
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(busy_vec) !== want) begin miscompares++; $display("[TB] FAIL full busy_vec got %0h expected %0h", busy_vec, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(busy_cnt) !== want) begin miscompares++; $display("[TB] FAIL full busy_cnt got %0d expected %0d", busy_cnt, want); end
        want = sbq.pop_front(); vectors++;
        if (32'(rsv_ok) !== want) begin miscompares++; $display("[TB] FAIL full extra rsv_ok got %0b expected %0b", rsv_ok, want); end
        cyc();
        idle();
        sbq.push_back(32'd8);
        @(negedge clk);
        want = sbq.pop_front(); vectors++;
        if (32'(busy_cnt) !== want) begin miscompares++; $display("[TB] FAIL full hold busy_cnt got %0d expected %0d", busy_cnt, want); end
    endtask

    initial begin
        test_reset();
        test_reserve_write();
        test_refuse();
        test_same_cycle();
        test_bypass_read();
        test_midrun_reset();
        test_fill();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard leftover entries got %0d expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
